// File: rtl/load_store_unit.sv
// load_store_unit: turns one load/store into a single req/ack bus transaction with lane handling
module load_store_unit #(
    parameter int FUNCT3_LENGTH  = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [FUNCT3_LENGTH-1:0] Funct3,
    input  logic [DATA_WIDTH-1:0]    Addr,
    input  logic [DATA_WIDTH-1:0]    StoreData,
    output logic [DATA_WIDTH-1:0]    LoadData,
    output logic                     Stall,
    output logic                     MisalignErr,
    output logic                     BusErr,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_be,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
    state_t state, state_n;
    logic is_load;
    logic [FUNCT3_LENGTH-1:0] f3;
    logic [1:0] lo;
    logic [7:0] cnt;
    logic start, legal, aligned, ok, timeout;
    logic [3:0] be_n;
    logic [31:0] wdata_n, ext;
    logic [7:0] rbyte;
    logic [15:0] rhalf;

    // request decode, lane formatting, load extraction and next state
    always_comb begin
        start   = MemRead | MemWrite;
        legal   = !(MemRead && MemWrite) && (Funct3 == 3'd0 || Funct3 == 3'd1 || Funct3 == 3'd2 ||
                  (MemRead && (Funct3 == 3'd4 || Funct3 == 3'd5)));
        aligned = Funct3[1] ? Addr[1:0] == 2'b00 : Funct3[0] ? !Addr[0] : 1'b1;
        ok      = legal && aligned;
        be_n    = Funct3[1] ? 4'b1111 : Funct3[0] ? (Addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << Addr[1:0];
        wdata_n = Funct3[1] ? StoreData : Funct3[0] ? {2{StoreData[15:0]}} : {4{StoreData[7:0]}};
        rbyte   = 8'(mem_rdata >> {lo, 3'b000});
        rhalf   = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext     = f3[1] ? mem_rdata :
                  f3[0] ? {{16{!f3[2] & rhalf[15]}}, rhalf} : {{24{!f3[2] & rbyte[7]}}, rbyte};
        timeout = cnt + 8'd1 == TMO;
        state_n = state == IDLE ? (start ? (ok ? REQ : DONE) : IDLE) :
                  state == REQ  ? ((mem_ack || timeout) ? DONE : REQ) : IDLE;
        Stall   = !reset && ((state == IDLE && start) || state == REQ);
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    // bus registers, latched request info, timeout counter and results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_load     <= 1'b0;
            f3          <= '0;
            lo          <= 2'b00;
            cnt         <= 8'd0;
            LoadData    <= '0;
            MisalignErr <= 1'b0;
            BusErr      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= 4'b0000;
        end else begin
            MisalignErr <= state == IDLE && start && !ok;
            BusErr      <= state == REQ && !mem_ack && timeout;
            if (state == IDLE && start) begin
                is_load <= MemRead;
                f3      <= Funct3;
                lo      <= Addr[1:0];
                cnt     <= 8'd0;
                if (ok) begin
                    mem_req   <= 1'b1;
                    mem_we    <= MemWrite;
                    mem_addr  <= {Addr[31:2], 2'b00};
                    mem_wdata <= wdata_n;
                    mem_be    <= be_n;
                end else LoadData <= '0;
            end
            if (state == REQ) begin
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    if (is_load) LoadData <= ext;
                end else if (timeout) begin
                    mem_req  <= 1'b0;
                    LoadData <= '0;
                end else cnt <= cnt + 8'd1;
            end
        end
    end
endmodule
